// File: rtl/sw_debounce.sv
// Switch conditioner: 2-flop synchroniser + per-bit debounce, with registered edge strobes.
// Define SW_DEBOUNCE_EDGE_EN to build sw_rise/sw_fall/mode_change; otherwise they are tied to 0.

module sw_debounce_bit #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic stable,
  output logic accept
);
  typedef enum logic {IDLE, CHECK} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= sw_raw;
      s2_q <= s1_q;
    end
  end

  // The state is the s2/stable comparison itself, so the first mismatch
  // cycle already counts; the counter is the only stored FSM context.
  always_comb state = (s2_q != stable_q) ? CHECK : IDLE;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    accept   = 1'b0;
    if (state == CHECK) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = s2_q;
        accept   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;
endmodule

module sw_debounce #(
  parameter  int WIDTH         = 4,
  parameter  int STABLE_CYCLES = 1000000,
  localparam int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic [2:0]       mode,
  output logic             mode_change
);
  logic [WIDTH-1:0] stable, accept;

  sw_debounce_bit #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_bit [WIDTH-1:0] (
    .clk   (clk),
    .rst   (rst),
    .sw_raw(sw_raw),
    .stable(stable),
    .accept(accept)
  );

`ifdef SW_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;
  logic             mc_q, mc_d;

  // stable still holds the pre-accept value here, so it tells the direction.
  always_comb begin
    rise_d = accept & ~stable;
    fall_d = accept & stable;
    mc_d   = |accept[2:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
      mc_q   <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
      mc_q   <= mc_d;
    end
  end

  assign sw_rise     = rise_q;
  assign sw_fall     = fall_q;
  assign mode_change = mc_q;
`else
  logic unused_accept;
  assign unused_accept = ^accept;
  assign sw_rise       = '0;
  assign sw_fall       = '0;
  assign mode_change   = 1'b0;
`endif

  assign sw_stable = stable;
  assign mode      = stable[2:0];
endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce (WIDTH=4, STABLE_CYCLES=4): stimulus pushes hand-computed
// per-edge expectations into a scoreboard queue; a negedge monitor pops and compares.
module tb_sw_debounce;
  localparam int W = 4;
  localparam int N = 4;
  localparam logic [3:0] Z = 4'b0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_stable, sw_rise, sw_fall;
  logic [2:0]   mode;
  logic         mode_change;

  sw_debounce #(.WIDTH(W), .STABLE_CYCLES(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_raw     (sw_raw),
    .sw_stable  (sw_stable),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .mode       (mode),
    .mode_change(mode_change)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] st;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       mc;
  } exp_t;

  exp_t  sb[$];
  int    n_vec = 0;
  int    n_err = 0;
  string phase = "reset";

  // One clock: apply inputs, expect the given state right after the edge.
  task automatic cyc(input logic r, input logic [3:0] raw, input logic [3:0] st,
                     input logic [3:0] rise, input logic [3:0] fall);
    exp_t e;
    rst    = r;
    sw_raw = raw;
    @(posedge clk);
    e.tag = phase;
    e.st  = st;
`ifdef SW_DEBOUNCE_EDGE_EN
    e.rise = rise;
    e.fall = fall;
    e.mc   = |(rise[2:0] | fall[2:0]);
`else
    e.rise = 4'b0000;
    e.fall = 4'b0000;
    e.mc   = 1'b0;
`endif
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (sw_stable !== e.st || sw_rise !== e.rise || sw_fall !== e.fall ||
          mode_change !== e.mc || mode !== e.st[2:0]) begin
        n_err++;
        $display("FAIL %s t=%0t: got stable=%b rise=%b fall=%b mc=%b mode=%b, want stable=%b rise=%b fall=%b mc=%b mode=%b",
                 e.tag, $time, sw_stable, sw_rise, sw_fall, mode_change, mode,
                 e.st, e.rise, e.fall, e.mc, e.st[2:0]);
      end
    end
  end

  initial begin
    phase = "reset";
    repeat (3) cyc(1'b1, Z, Z, Z, Z);
    phase = "post_reset";
    repeat (20) cyc(1'b0, Z, Z, Z, Z);

    phase = "clean_rise";
    repeat (5) cyc(1'b0, 4'b0101, Z, Z, Z);
    cyc(1'b0, 4'b0101, 4'b0101, 4'b0101, Z);
    repeat (4) cyc(1'b0, 4'b0101, 4'b0101, Z, Z);

    phase = "clean_fall";
    repeat (5) cyc(1'b0, Z, 4'b0101, Z, Z);
    cyc(1'b0, Z, Z, Z, 4'b0101);
    repeat (3) cyc(1'b0, Z, Z, Z, Z);

    phase = "bounce";
    cyc(1'b0, 4'b0001, Z, Z, Z);
    cyc(1'b0, 4'b0000, Z, Z, Z);
    cyc(1'b0, 4'b0001, Z, Z, Z);
    cyc(1'b0, 4'b0000, Z, Z, Z);
    repeat (5) cyc(1'b0, 4'b0001, Z, Z, Z);
    cyc(1'b0, 4'b0001, 4'b0001, 4'b0001, Z);
    repeat (3) cyc(1'b0, 4'b0001, 4'b0001, Z, Z);

    phase = "glitch";
    repeat (3) cyc(1'b0, 4'b0011, 4'b0001, Z, Z);
    repeat (9) cyc(1'b0, 4'b0001, 4'b0001, Z, Z);

    phase = "high_bit";
    repeat (5) cyc(1'b0, 4'b1001, 4'b0001, Z, Z);
    cyc(1'b0, 4'b1001, 4'b1001, 4'b1000, Z);
    repeat (3) cyc(1'b0, 4'b1001, 4'b1001, Z, Z);

    phase = "mid_count_rst";
    repeat (3) cyc(1'b0, 4'b1101, 4'b1001, Z, Z);
    repeat (2) cyc(1'b1, 4'b1101, Z, Z, Z);
    phase = "after_rst";
    repeat (5) cyc(1'b0, 4'b1101, Z, Z, Z);
    cyc(1'b0, 4'b1101, 4'b1101, 4'b1101, Z);
    repeat (3) cyc(1'b0, 4'b1101, 4'b1101, Z, Z);

    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
